// File: rtl/global_pkg.sv
// Shared types and constants for the Wishbone master-side arbitration path.
// Imported by the arbiter and its helper blocks.
package global_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_TERM
  } arb_state_t;

  // Same reply cross_bar gives for an unmapped address
  localparam logic [31:0] WB_ERR_DATA = 32'h0000_0000;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '0;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin pick: first set req bit after last_ptr, wrapping modulo N_MASTER.
// Purely combinational.
module rr_priority_encoder #(
  parameter int N_MASTER = 2,
  parameter int GW       = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [GW-1:0]       last_ptr,
  output logic                any,
  output logic [GW-1:0]       idx
);

  // Scan farthest-first so the nearest requester overwrites last
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N_MASTER; k >= 1; k--) begin
      for (int i = 0; i < N_MASTER; i++) begin
        if (i == (int'(last_ptr) + k) % N_MASTER && req[i])
          idx = GW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone B4 master arbiter in front of cross_bar,
// with a watchdog that error-terminates unacknowledged strobes.
module wb_master_arbiter
  import global_pkg::*;
#(
  parameter int N_MASTER       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GW             = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTER-1:0]    m_cyc,
  input  logic [N_MASTER-1:0]    m_stb,
  input  logic [N_MASTER-1:0]    m_we,
  input  logic [N_MASTER*32-1:0] m_adr,
  input  logic [N_MASTER*32-1:0] m_dat_o,
  output logic [31:0]            m_dat_i,
  output logic [N_MASTER-1:0]    m_ack,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [31:0]            s_adr,
  output logic [31:0]            s_dat_o,
  input  logic [31:0]            s_dat_i,
  input  logic                   s_ack,
  output logic                   grant_valid,
  output logic [GW-1:0]          grant_idx,
  output logic                   timeout_err
);

  localparam int WDW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] PTR_INIT = GW'(N_MASTER - 1);

  arb_state_t     state;
  logic [GW-1:0]  last_ptr;
  logic [WDW-1:0] wd_cnt;
  wb_req_t        own;
  logic           rr_any;
  logic [GW-1:0]  rr_idx;
  logic           wd_on;
  logic           wd_stall;
  logic           wd_expire;

  rr_priority_encoder #(
    .N_MASTER (N_MASTER),
    .GW       (GW)
  ) u_rr (
    .req      (m_cyc),
    .last_ptr (last_ptr),
    .any      (rr_any),
    .idx      (rr_idx)
  );

  always_comb begin
    own = WB_REQ_IDLE;
    for (int i = 0; i < N_MASTER; i++) begin
      if (grant_idx == GW'(i)) begin
        own.cyc = m_cyc[i];
        own.stb = m_stb[i];
        own.we  = m_we[i];
        own.adr = m_adr[32*i +: 32];
        own.dat = m_dat_o[32*i +: 32];
      end
    end
  end

  assign wd_on     = TIMEOUT_CYCLES > 0;
  assign wd_stall  = wd_on && own.stb && !s_ack;
  assign wd_expire = wd_stall && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_ptr    <= PTR_INIT;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          wd_cnt <= '0;
          if (rr_any) begin
            grant_idx   <= rr_idx;
            grant_valid <= 1'b1;
            state       <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (!own.cyc) begin
            state       <= ARB_IDLE;
            last_ptr    <= grant_idx;
            grant_valid <= 1'b0;
            wd_cnt      <= '0;
          end else if (wd_expire) begin
            state       <= ARB_TERM;
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
          end else if (wd_stall) begin
            wd_cnt <= wd_cnt + WDW'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        ARB_TERM: begin
          state  <= ARB_OWN;
          wd_cnt <= '0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Bus side follows state directly so an async reset clears it at once
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    m_dat_i = '0;
    m_ack   = '0;
    unique case (state)
      ARB_OWN: begin
        s_cyc   = own.cyc;
        s_stb   = own.stb;
        s_we    = own.we;
        s_adr   = own.adr;
        s_dat_o = own.dat;
        m_dat_i = s_dat_i;
        for (int i = 0; i < N_MASTER; i++)
          m_ack[i] = (grant_idx == GW'(i)) && s_ack;
      end
      ARB_TERM: begin
        s_cyc   = 1'b1;
        s_we    = own.we;
        s_adr   = own.adr;
        s_dat_o = own.dat;
        m_dat_i = WB_ERR_DATA;
        for (int i = 0; i < N_MASTER; i++)
          m_ack[i] = grant_idx == GW'(i);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
Round-robin Wishbone B4 bus arbiter that sits directly upstream of cross_bar. It selects one of N_MASTER masters (CPU fetch, CPU data, DMA, debug) and forwards that owner's cycle on a single master-side port into the crossbar's address decoder. It routes the returned DAT/ACK only to the owner. A watchdog terminates cycles that no slave acknowledges.

Parameters:
N_MASTER, 2, number of requesting masters (1..8)
TIMEOUT_CYCLES, 255, STB-high cycles without ACK before forced termination; 0 disables the watchdog
GW, $clog2(N_MASTER) with a minimum of 1, width of the grant index (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
m_cyc  in  N_MASTER  per-master CYC
m_stb  in  N_MASTER  per-master STB
m_we  in  N_MASTER  per-master WE
m_adr  in  N_MASTER*32  per-master ADR; master i occupies bits [32*i+31:32*i]
m_dat_o  in  N_MASTER*32  per-master write data, packed like m_adr
m_dat_i  out  32  read data, broadcast to all masters
m_ack  out  N_MASTER  per-master ACK; only the owner's bit can be 1
s_cyc  out  1  CYC to cross_bar
s_stb  out  1  STB to cross_bar
s_we  out  1  WE to cross_bar
s_adr  out  32  ADR to cross_bar
s_dat_o  out  32  write data to cross_bar
s_dat_i  in  32  read data from cross_bar
s_ack  in  1  ACK from cross_bar
grant_valid  out  1  a master currently owns the bus
grant_idx  out  GW  index of the owner
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst=0, async): state=IDLE; grant_valid=0; grant_idx=0; last_ptr=N_MASTER-1, so master 0 wins first; wd_cnt=0; timeout_err=0; all s_* outputs 0; m_ack=0; m_dat_i=0.
- States: IDLE, OWN, TERM.
- IDLE:
  - s_* outputs are 0.
  - If any m_cyc bit is 1, pick the first requester scanning last_ptr+1, last_ptr+2, ... modulo N_MASTER.
  - Register that index into grant_idx, set grant_valid=1, go to OWN.
  - Arbitration latency is 1 cycle from CYC assertion to s_cyc.
- OWN:
  - s_cyc/s_stb/s_we/s_adr/s_dat_o are combinational copies of the owner's signals.
  - m_ack[owner]=s_ack; all other m_ack bits are 0. m_dat_i=s_dat_i.
  - The bus is locked while m_cyc[owner]=1; other requests wait. The owner may run multiple STB phases.
  - When m_cyc[owner]=0: go to IDLE, set last_ptr=owner, set grant_valid=0. There is at least one dead cycle between owners.
- Watchdog (TIMEOUT_CYCLES>0):
  - In OWN, wd_cnt increments each cycle where s_stb=1 and s_ack=0.
  - wd_cnt clears on s_ack=1, on s_stb=0, and on leaving OWN.
  - When wd_cnt==TIMEOUT_CYCLES-1 and s_ack=0, go to TERM.
- TERM (exactly 1 cycle):
  - s_stb=0, s_cyc=1.
  - m_ack[owner]=1 with m_dat_i=WB_ERR_DATA; timeout_err=1.
  - Next state is OWN (the owner keeps the bus) with wd_cnt=0.
  - A late s_ack arriving during TERM is ignored.
- Simultaneous events:
  - ACK on the same cycle the counter would expire: the ACK wins, with no TERM and no pulse.
  - Owner drops CYC on the cycle another master raises CYC: the new master is granted on the following IDLE cycle.
- N_MASTER=1: the rotation degenerates, and grant_idx is always 0.
- Reset mid-operation: all outputs return to reset values immediately. Any outstanding slave ACK is dropped.
- wd_cnt width is $clog2(TIMEOUT_CYCLES+1); the counter must not wrap.

Decomposition:
- global_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_OWN, ARB_TERM}
  - WB_ERR_DATA = 32'h00000000, matching cross_bar's unmapped-address reply
- Sub-module rr_priority_encoder: purely combinational. Inputs are req[N_MASTER] and last_ptr. Outputs are any and idx.

Test Plan:
- Reset: hold rst=0 with m_cyc=2'b11 -> grant_valid=0, s_cyc=0, m_ack=0. After release, grant_idx=0 and s_cyc=1 one cycle later.
- Single master: master1 writes ADR=0x00100000, DAT=0x41, WE=1, and the slave ACKs after 2 cycles -> s_adr=0x00100000, s_dat_o=0x41, m_ack=2'b10 for one cycle, m_ack[0] never 1.
- Round-robin: both masters hold CYC continuously, and each drops CYC after one ACKed read -> grant sequence 0,1,0,1 with one IDLE cycle between owners.
- Lock: master0 holds CYC through 3 STB/ACK phases while master1 requests -> grant_idx stays 0 for all three. Master1 is granted only after master0 drops CYC.
- Timeout: TIMEOUT_CYCLES=4, master0 reads with s_ack tied 0 -> after 4 STB cycles, timeout_err pulses, m_ack[0]=1, m_dat_i=0x00000000, s_stb=0 in that cycle.
- Async reset mid-cycle: assert rst=0 while in OWN with s_stb=1 -> s_cyc, s_stb and grant_valid drop to 0 without waiting for a clock edge.
